norm1_mul_arbiter: RTL and testbench
====================================

# norm1_mul_arbiter

Shares one unsigned 18×18→36 multiplier among `NUM_REQ` requesters inside the norm1 (LRN) stage. Arbitration is round-robin with a valid/ready handshake on each input. Operands and product are registered in a two-stage pipeline. A single result channel with backpressure returns each product tagged with the requester index. Use this block wherever several norm1 loops (square-sum, scaling, power approximation) would otherwise each need their own DSP multiplier.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `ID_W`, 2, requester tag width; must satisfy 2^ID_W ≥ NUM_REQ
- `din0_WIDTH`, 18, operand A width
- `din1_WIDTH`, 18, operand B width
- `dout_WIDTH`, 36, product width = din0_WIDTH + din1_WIDTH

Ports:
- `ap_clk`  in  1  single clock; all state updates on the rising edge
- `ap_rst`  in  1  synchronous reset, active-high
- `req_vld`  in  NUM_REQ  per-requester operand valid
- `req_rdy`  out  NUM_REQ  per-requester grant/accept; one-hot or zero
- `req_din0`  in  NUM_REQ*din0_WIDTH  operand A; requester i uses slice [i*din0_WIDTH +: din0_WIDTH]
- `req_din1`  in  NUM_REQ*din1_WIDTH  operand B; same slicing as `req_din0`
- `res_vld`  out  1  result valid
- `res_rdy`  in  1  result consumer ready
- `res_dout`  out  dout_WIDTH  unsigned product din0*din1
- `res_id`  out  ID_W  index of the requester that issued the operands
- `busy`  out  1  any pipeline stage holds a valid entry

## Operation
- **Pipeline registers:**
  - S1 holds `s1_vld`, `s1_id`, `s1_a`, `s1_b`.
  - S2 holds `s2_vld`, `s2_id`, `s2_p`.
  - `res_vld`=`s2_vld`, `res_dout`=`s2_p`, `res_id`=`s2_id`.
- **Stall logic:**
  - `adv2` = !s2_vld | res_rdy
  - `adv1` = !s1_vld | adv2
- **Arbitration:**
  - Runs combinationally when `adv1`=1.
  - Grants the first requester with `req_vld` high, searching from `rr_ptr` upward with wrap modulo NUM_REQ.
  - `req_rdy[g]`=1 only for the granted requester g. All `req_rdy` bits are 0 when `adv1`=0 or no request is pending.
  - `req_rdy` may depend on `req_vld`. Requesters must not make `req_vld` depend on `req_rdy`.
- **Transfer:** a handshake occurs when `req_vld[g]` & `req_rdy[g]`. On that edge:
  - S1 loads g and the sliced operands.
  - `rr_ptr` ← (g+1) mod NUM_REQ.
- **Pointer hold:** with no grant, `rr_ptr` holds. When `adv1`=1 with no grant, `s1_vld` ← 0.
- **Stage S1→S2:** when `adv2`=1:
  - `s2_p` ← {0,s1_a}*{0,s1_b} (unsigned, full width, no truncation).
  - `s2_id`, `s2_vld` ← S1 values.
- **Hold:** when `adv2`=0, S2 holds and S1 holds.
- **Requester obligations:** operands held stable while `req_vld` is high and not yet accepted. Dropping `req_vld` before acceptance is allowed; nothing is issued.
- **Ordering:** results leave in grant order. The block performs no reordering.
- **`busy`** = s1_vld | s2_vld.
- **Reset** (`ap_rst`=1 at an edge):
  - `s1_vld`, `s2_vld` ← 0; `rr_ptr` ← 0; `s1_*`, `s2_p`, `s2_id` ← 0.
  - Outputs after reset: `res_vld`=0, `res_dout`=0, `res_id`=0, `busy`=0, `req_rdy`=0 during reset.
  - Reset during operation discards in-flight entries with no result emitted. The block accepts no handshake in a reset cycle.

## Timing
- **Latency:** handshake at edge k → `res_vld`=1 with the product after edge k+1, i.e. 2 cycles to visibility, when `res_rdy` is held high.
- **Throughput:** 1 result/cycle sustained with `res_rdy`=1 and at least one request pending.
- **Backpressure:**
  - `res_rdy`=0 with S2 full freezes S2.
  - S1 is accepted only if empty. With both stages full, `req_rdy`=0 in the same cycle.
  - The pipeline refills with no bubble once `res_rdy` returns.
- **Fairness:** with all requesters continuously valid, grants cycle 0,1,2,3,0,… Any persistent requester is served within NUM_REQ grants.
- **Simultaneous events:** `res_rdy`=1 while S2 full and S1 full → S2 pops, S1→S2, and a new grant loads S1, all in one cycle.

## Test plan
- **Single request:** reset, then requester 2 presents A=3FFFF, B=3FFFF with `res_rdy`=1 → `req_rdy`=0100 same cycle; 2 cycles later `res_vld`=1, `res_dout`=F_FFF8_0001, `res_id`=2 for one cycle.
- **Round-robin:** all 4 requesters valid continuously, operands (i+1, 10) → `res_id` sequence 0,1,2,3,0,…; products 10,20,30,40; one result per cycle.
- **Backpressure:** stream from requester 0, drop `res_rdy` for 5 cycles → within 2 cycles `req_rdy`=0, `res_dout`/`res_id` stable; on release, no lost or duplicated results and order is preserved.
- **Pointer wrap:** only requesters 3 and 0 valid, starting from `rr_ptr`=3 → grants 3,0,3,0; requester 1 asserting mid-stream is granted next after 0.
- **Reset during operation:** reset asserted with both stages full → next cycle `res_vld`=0, `busy`=0; the first grant after reset goes to the lowest valid index starting at 0.
- **Boundary operands:** A=0 / B=3FFFF → 0; A=1 / B=20000 → 20000; the result is checked against a 36-bit unsigned reference model over 10k random operands with random `res_rdy`.

Source files
------------

// File: rtl/norm1_mul_arbiter.sv
// rtl/norm1_mul_arbiter.sv - round-robin shared 18x18 unsigned multiplier for the norm1 stage
// Two registered stages (operands, product) with a single backpressured, id-tagged result channel.
module norm1_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int din0_WIDTH = 18,
    parameter int din1_WIDTH = 18,
    parameter int dout_WIDTH = 36
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [NUM_REQ-1:0]               req_vld,
    output logic [NUM_REQ-1:0]               req_rdy,
    input  logic [NUM_REQ*din0_WIDTH-1:0]    req_din0,
    input  logic [NUM_REQ*din1_WIDTH-1:0]    req_din1,
    output logic                             res_vld,
    input  logic                             res_rdy,
    output logic [dout_WIDTH-1:0]            res_dout,
    output logic [ID_W-1:0]                  res_id,
    output logic                             busy
);

    logic                  s1_vld_q, s1_vld_d;
    logic [ID_W-1:0]       s1_id_q, s1_id_d;
    logic [din0_WIDTH-1:0] s1_a_q, s1_a_d;
    logic [din1_WIDTH-1:0] s1_b_q, s1_b_d;
    logic                  s2_vld_q, s2_vld_d;
    logic [ID_W-1:0]       s2_id_q, s2_id_d;
    logic [dout_WIDTH-1:0] s2_p_q, s2_p_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic            adv1, adv2;
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;

    always_comb begin
        adv2 = !s2_vld_q || res_rdy;
        adv1 = !s1_vld_q || adv2;

        // Search from rr_ptr upward, wrapping modulo NUM_REQ; first valid wins.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_vld[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end

        req_rdy = '0;
        if (adv1 && grant_found && !ap_rst) begin
            req_rdy[grant_idx] = 1'b1;
        end

        s1_vld_d = s1_vld_q;
        s1_id_d  = s1_id_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s2_vld_d = s2_vld_q;
        s2_id_d  = s2_id_q;
        s2_p_d   = s2_p_q;
        rr_ptr_d = rr_ptr_q;

        if (adv2) begin
            s2_vld_d = s1_vld_q;
            s2_id_d  = s1_id_q;
            s2_p_d   = dout_WIDTH'(s1_a_q) * dout_WIDTH'(s1_b_q);
        end

        if (adv1) begin
            s1_vld_d = grant_found;
            if (grant_found) begin
                s1_id_d  = grant_idx;
                s1_a_d   = req_din0[grant_idx*din0_WIDTH +: din0_WIDTH];
                s1_b_d   = req_din1[grant_idx*din1_WIDTH +: din1_WIDTH];
                rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_vld_q <= 1'b0;
            s1_id_q  <= '0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_id_q  <= '0;
            s2_p_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_id_q  <= s1_id_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s2_vld_q <= s2_vld_d;
            s2_id_q  <= s2_id_d;
            s2_p_q   <= s2_p_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign res_vld  = s2_vld_q;
    assign res_dout = s2_p_q;
    assign res_id   = s2_id_q;
    assign busy     = s1_vld_q | s2_vld_q;

endmodule

// File: tb/tb_norm1_mul_arbiter.sv
// tb/tb_norm1_mul_arbiter.sv - scoreboard bench for norm1_mul_arbiter
// Directed vectors push hand-computed results; a negedge monitor pops and compares.
module tb_norm1_mul_arbiter;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int AW = 18;
    localparam int BW = 18;
    localparam int PW = 36;
    localparam int N_RAND = 10000;

    logic             ap_clk = 1'b0;
    logic             ap_rst;
    logic [NR-1:0]    req_vld;
    logic [NR-1:0]    req_rdy;
    logic [NR*AW-1:0] req_din0;
    logic [NR*BW-1:0] req_din1;
    logic             res_vld;
    logic             res_rdy;
    logic [PW-1:0]    res_dout;
    logic [IW-1:0]    res_id;
    logic             busy;

    norm1_mul_arbiter #(
        .NUM_REQ(NR), .ID_W(IW), .din0_WIDTH(AW), .din1_WIDTH(BW), .dout_WIDTH(PW)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_din0(req_din0), .req_din1(req_din1),
        .res_vld(res_vld), .res_rdy(res_rdy),
        .res_dout(res_dout), .res_id(res_id), .busy(busy)
    );

    always #5 ap_clk = ~ap_clk;

    int            vectors = 0;
    int            miscompares = 0;
    int            issued = 0;
    bit            auto_push = 1'b0;
    logic [IW-1:0] q_id[$];
    logic [PW-1:0] q_p[$];
    logic [IW-1:0] exp_id;
    logic [PW-1:0] exp_p;
    logic [PW-1:0] ref_a, ref_b;
    logic [NR-1:0] hs;
    logic [PW-1:0] hold_dout;
    logic [IW-1:0] hold_id;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        req_din0[i*AW +: AW] = a;
        req_din1[i*BW +: BW] = b;
    endtask

    task automatic push(input int id, input logic [PW-1:0] p);
        q_id.push_back(IW'(id));
        q_p.push_back(p);
    endtask

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic drain(input string name);
        for (int n = 0; n < 200 && (q_id.size() != 0 || busy); n++) @(negedge ap_clk);
        @(negedge ap_clk);
        check(name, 64'(q_id.size()), 0);
        tick();
    endtask

    task automatic do_reset();
        tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
    endtask

    // Result monitor plus per-cycle grant sanity; in random mode it also records accepted operands.
    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (res_vld && res_rdy) begin
                if (q_id.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: got id %0d dout %0h expected no result", res_id, res_dout);
                end else begin
                    exp_id = q_id.pop_front();
                    exp_p  = q_p.pop_front();
                    check("res_id", 64'(res_id), 64'(exp_id));
                    check("res_dout", 64'(res_dout), 64'(exp_p));
                end
            end
            check("rdy_onehot0", 64'($onehot0(req_rdy)), 1);
            check("rdy_implies_vld", 64'(req_rdy & ~req_vld), 0);
            if (auto_push) begin
                for (int i = 0; i < NR; i++) begin
                    if (req_vld[i] && req_rdy[i]) begin
                        ref_a = PW'(req_din0[i*AW +: AW]);
                        ref_b = PW'(req_din1[i*BW +: BW]);
                        push(i, ref_a * ref_b);
                        issued++;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    int bp_n;
    int wrap_seq[7] = '{3, 0, 3, 0, 1, 3, 0};
    logic [PW-1:0] wrap_p[7] = '{36'd35, 36'd18, 36'd35, 36'd18, 36'd16, 36'd35, 36'd18};

    initial begin
        ap_rst   = 1'b1;
        req_vld  = '1;
        req_din0 = '0;
        req_din1 = '0;
        res_rdy  = 1'b0;
        tick();
        tick();
        @(negedge ap_clk);
        check("rst_res_vld", 64'(res_vld), 0);
        check("rst_res_dout", 64'(res_dout), 0);
        check("rst_res_id", 64'(res_id), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_req_rdy", 64'(req_rdy), 0);
        tick();
        ap_rst  = 1'b0;
        req_vld = '0;
        res_rdy = 1'b1;

        // Single request, max operands, latency
        set_op(2, 18'h3FFFF, 18'h3FFFF);
        req_vld = 4'b0100;
        @(negedge ap_clk);
        check("single_rdy", 64'(req_rdy), 64'(4'b0100));
        push(2, 36'hF_FFF8_0001);
        tick();
        req_vld = '0;
        @(negedge ap_clk);
        check("single_lat1_vld", 64'(res_vld), 0);
        check("single_lat1_busy", 64'(busy), 1);
        @(negedge ap_clk);
        check("single_lat2_vld", 64'(res_vld), 1);
        @(negedge ap_clk);
        check("single_lat3_vld", 64'(res_vld), 0);
        check("single_idle_busy", 64'(busy), 0);
        tick();

        // Round robin with all requesters valid
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, AW'(i + 1), 18'd10);
        req_vld = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge ap_clk);
            check("rr_grant", 64'(req_rdy), 64'(onehot(k % 4)));
            push(k % 4, PW'((k % 4 + 1) * 10));
            tick();
        end
        req_vld = '0;
        drain("rr_drain");

        // Backpressure on a stream from requester 0
        bp_n = 0;
        set_op(0, 18'd1, 18'd3);
        req_vld = 4'b0001;
        res_rdy = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge ap_clk);
            if (req_rdy[0]) begin
                push(0, PW'((bp_n + 1) * 3));
                bp_n++;
            end
            if (c == 4) begin
                hold_dout = res_dout;
                hold_id   = res_id;
                check("bp_full_vld", 64'(res_vld), 1);
            end
            if (c >= 5 && c <= 8) begin
                check("bp_rdy_low", 64'(req_rdy), 0);
                check("bp_dout_hold", 64'(res_dout), 64'(hold_dout));
                check("bp_id_hold", 64'(res_id), 64'(hold_id));
            end
            tick();
            set_op(0, AW'(bp_n + 1), 18'd3);
            res_rdy = !(c >= 3 && c < 8);
        end
        req_vld = '0;
        res_rdy = 1'b1;
        drain("bp_drain");

        // Move pointer to 3, then wrap between 3 and 0; requester 1 joins late
        set_op(2, 18'd2, 18'd2);
        req_vld = 4'b0100;
        @(negedge ap_clk);
        check("wrap_pre_rdy", 64'(req_rdy), 64'(4'b0100));
        push(2, 36'd4);
        tick();
        set_op(3, 18'd5, 18'd7);
        set_op(0, 18'd2, 18'd9);
        set_op(1, 18'd4, 18'd4);
        req_vld = 4'b1001;
        for (int k = 0; k < 7; k++) begin
            @(negedge ap_clk);
            check("wrap_grant", 64'(req_rdy), 64'(onehot(wrap_seq[k])));
            push(wrap_seq[k], wrap_p[k]);
            tick();
            if (k == 3) req_vld[1] = 1'b1;
        end
        req_vld = '0;
        drain("wrap_drain");

        // Reset with both stages full
        set_op(1, 18'd6, 18'd7);
        res_rdy = 1'b0;
        req_vld = 4'b0010;
        tick();
        tick();
        tick();
        @(negedge ap_clk);
        check("full_busy", 64'(busy), 1);
        check("full_res_vld", 64'(res_vld), 1);
        check("full_rdy", 64'(req_rdy), 0);
        tick();
        ap_rst  = 1'b1;
        req_vld = 4'b1010;
        @(negedge ap_clk);
        check("inrst_rdy", 64'(req_rdy), 0);
        tick();
        ap_rst  = 1'b0;
        res_rdy = 1'b1;
        @(negedge ap_clk);
        check("postrst_vld", 64'(res_vld), 0);
        check("postrst_busy", 64'(busy), 0);
        check("postrst_grant", 64'(req_rdy), 64'(4'b0010));
        push(1, 36'd42);
        tick();
        req_vld = '0;
        drain("rst_drain");

        // Boundary operands
        set_op(0, 18'd0, 18'h3FFFF);
        req_vld = 4'b0001;
        @(negedge ap_clk);
        check("bnd0_rdy", 64'(req_rdy), 64'(4'b0001));
        push(0, 36'd0);
        tick();
        set_op(0, 18'd1, 18'h20000);
        @(negedge ap_clk);
        check("bnd1_rdy", 64'(req_rdy), 64'(4'b0001));
        push(0, 36'h20000);
        tick();
        req_vld = '0;
        drain("bnd_drain");

        // Random operands and random result backpressure against the reference product
        auto_push = 1'b1;
        issued    = 0;
        for (int c = 0; c < 60000 && issued < N_RAND; c++) begin
            @(negedge ap_clk);
            hs = req_vld & req_rdy;
            tick();
            for (int i = 0; i < NR; i++) begin
                if (hs[i] || !req_vld[i]) begin
                    req_vld[i] = 1'($urandom_range(0, 1));
                    set_op(i, AW'($urandom), BW'($urandom));
                end
            end
            res_rdy = ($urandom_range(0, 3) != 0);
        end
        req_vld = '0;
        res_rdy = 1'b1;
        drain("rand_drain");
        auto_push = 1'b0;
        check("rand_issued", 64'(issued >= N_RAND), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
